// File: rtl/smem_interval_store_pkg.sv
// Shared constants and types for the backward-extension interval store.
// Imported by the store, its banks and the backward stages.
package smem_pkg;

  localparam int ADDR_W = 7;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int DATA_W = 64;

  typedef struct packed {
    logic [DATA_W-1:0] x0;
    logic [DATA_W-1:0] x1;
    logic [DATA_W-1:0] x2;
    logic [DATA_W-1:0] info;
  } interval_t;

  // Interval status codes carried in the info word by the backward stages.
  localparam logic [1:0] ST_NONE = 2'd0;
  localparam logic [1:0] ST_CURR = 2'd1;
  localparam logic [1:0] ST_MEM  = 2'd2;
  localparam logic [1:0] ST_BOTH = 2'd3;

endpackage

// File: rtl/smem_interval_store_if.sv
// Write/read bus between backward stage 1 (master) and the interval store (slave).
interface smem_interval_store_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 64
);
  logic              stall;
  logic              swap;
  logic              clr_mem;
  logic              store_valid_curr;
  logic [DATA_W-1:0] curr_x_0, curr_x_1, curr_x_2, curr_x_info;
  logic [ADDR_W-1:0] curr_x_addr;
  logic              store_valid_mem;
  logic [DATA_W-1:0] mem_x_0, mem_x_1, mem_x_2, mem_x_info;
  logic [ADDR_W-1:0] mem_x_addr;
  logic              rd_en;
  logic [ADDR_W-1:0] current_rd_addr;
  logic [DATA_W-1:0] p_x0, p_x1, p_x2, p_info;
  logic              rd_valid;
  logic              rd_hit;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_x0, mem_rd_x1, mem_rd_x2, mem_rd_info;
  logic              mem_rd_valid;
  logic [ADDR_W:0]   curr_count;
  logic [ADDR_W:0]   mem_count;

  modport master (
    output stall, swap, clr_mem,
    output store_valid_curr, curr_x_0, curr_x_1, curr_x_2, curr_x_info, curr_x_addr,
    output store_valid_mem, mem_x_0, mem_x_1, mem_x_2, mem_x_info, mem_x_addr,
    output rd_en, current_rd_addr, mem_rd_en, mem_rd_addr,
    input  p_x0, p_x1, p_x2, p_info, rd_valid, rd_hit,
    input  mem_rd_x0, mem_rd_x1, mem_rd_x2, mem_rd_info, mem_rd_valid,
    input  curr_count, mem_count
  );

  modport slave (
    input  stall, swap, clr_mem,
    input  store_valid_curr, curr_x_0, curr_x_1, curr_x_2, curr_x_info, curr_x_addr,
    input  store_valid_mem, mem_x_0, mem_x_1, mem_x_2, mem_x_info, mem_x_addr,
    input  rd_en, current_rd_addr, mem_rd_en, mem_rd_addr,
    output p_x0, p_x1, p_x2, p_info, rd_valid, rd_hit,
    output mem_rd_x0, mem_rd_x1, mem_rd_x2, mem_rd_info, mem_rd_valid,
    output curr_count, mem_count
  );

endinterface

// File: rtl/smem_interval_store_bank.sv
// smem_bank: DEPTH-entry register file with per-entry valid bits, bulk clear,
// one write port and one registered read port (raw data plus registered hit).
module smem_bank import smem_pkg::*; #(
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 128,
  parameter int W      = 256,
  parameter bit BYPASS = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic              cnt_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [W-1:0]      wr_data,
  output logic              wr_new,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [W-1:0]      rd_data,
  output logic              rd_hit
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [DEPTH-1:0] valid_reg, valid_next;
  // Tracks entries already counted by the owner; a write under stall sets
  // valid but leaves the entry uncounted so the re-presented write counts once.
  logic [DEPTH-1:0] cnt_reg, cnt_next;
  logic [W-1:0]     rd_data_reg;
  logic             rd_hit_reg;
  logic             byp_hit;

  assign byp_hit = BYPASS && wr_en && (wr_addr == rd_addr);
  assign wr_new  = ~cnt_reg[wr_addr];
  assign rd_data = rd_data_reg;
  assign rd_hit  = rd_hit_reg;

  always_comb begin
    valid_next = clr ? '0 : valid_reg;
    cnt_next   = clr ? '0 : cnt_reg;
    if (wr_en) begin
      valid_next[wr_addr] = 1'b1;
      if (cnt_en) cnt_next[wr_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg  <= '0;
      cnt_reg    <= '0;
      rd_hit_reg <= 1'b0;
    end else begin
      valid_reg <= valid_next;
      cnt_reg   <= cnt_next;
      if (rd_en) rd_hit_reg <= byp_hit | valid_reg[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data_reg <= byp_hit ? wr_data : mem_q[rd_addr];
  end

endmodule

// File: rtl/smem_interval_store.sv
// Interval store: ping-pong curr banks swapped per iteration plus a mem bank.
// Define SMEM_STORE_BYPASS_EN for write-first behaviour on the mem port.
module smem_interval_store import smem_pkg::*; #(
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 128,
  parameter int DATA_W = 64
) (
  input logic                 clk,
  input logic                 rst,
  smem_interval_store_if.slave bus
);

  localparam int              ENTRY_W = 4 * DATA_W;
  localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W + 1)'(DEPTH);
`ifdef SMEM_STORE_BYPASS_EN
  localparam bit MEM_BYPASS = 1'b1;
`else
  localparam bit MEM_BYPASS = 1'b0;
`endif

  logic                wr_sel_reg, wr_sel_next;
  logic                rd_bank_reg;
  logic                rd_valid_reg, mem_rd_valid_reg;
  logic [ADDR_W:0]     curr_count_reg, curr_count_next;
  logic [ADDR_W:0]     mem_count_reg, mem_count_next;
  logic                swap_go, rd_go, mem_rd_go;
  logic [ENTRY_W-1:0]  curr_wr_data, mem_wr_data, mem_rd_data, p_data, m_data;
  logic [ENTRY_W-1:0]  curr_rd_data [2];
  logic [1:0]          curr_rd_hit, curr_wr_new;
  logic                mem_wr_new, mem_rd_hit;

  assign swap_go   = bus.swap & ~bus.stall;
  assign rd_go     = bus.rd_en & ~bus.stall;
  assign mem_rd_go = bus.mem_rd_en & ~bus.stall;

  assign curr_wr_data = {bus.curr_x_0, bus.curr_x_1, bus.curr_x_2, bus.curr_x_info};
  assign mem_wr_data  = {bus.mem_x_0, bus.mem_x_1, bus.mem_x_2, bus.mem_x_info};

  // On swap the bank about to become the write bank (the current read bank) is cleared;
  // a same-cycle write still lands in the outgoing write bank.
  for (genvar gi = 0; gi < 2; gi++) begin : g_curr
    localparam logic BANK = 1'(gi);
    smem_bank #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .W(ENTRY_W), .BYPASS(1'b0)) u_bank (
      .clk     (clk),
      .rst     (rst),
      .clr     (swap_go && (wr_sel_reg != BANK)),
      .wr_en   (bus.store_valid_curr && (wr_sel_reg == BANK)),
      .cnt_en  (~bus.stall),
      .wr_addr (bus.curr_x_addr),
      .wr_data (curr_wr_data),
      .wr_new  (curr_wr_new[gi]),
      .rd_en   (rd_go && (wr_sel_reg != BANK)),
      .rd_addr (bus.current_rd_addr),
      .rd_data (curr_rd_data[gi]),
      .rd_hit  (curr_rd_hit[gi])
    );
  end

  smem_bank #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .W(ENTRY_W), .BYPASS(MEM_BYPASS)) u_mem_bank (
    .clk     (clk),
    .rst     (rst),
    .clr     (bus.clr_mem),
    .wr_en   (bus.store_valid_mem),
    .cnt_en  (~bus.stall),
    .wr_addr (bus.mem_x_addr),
    .wr_data (mem_wr_data),
    .wr_new  (mem_wr_new),
    .rd_en   (mem_rd_go),
    .rd_addr (bus.mem_rd_addr),
    .rd_data (mem_rd_data),
    .rd_hit  (mem_rd_hit)
  );

  always_comb begin
    wr_sel_next     = wr_sel_reg ^ swap_go;
    curr_count_next = curr_count_reg;
    mem_count_next  = mem_count_reg;
    if (swap_go)
      curr_count_next = '0;
    else if (bus.store_valid_curr && !bus.stall && curr_wr_new[wr_sel_reg] &&
             curr_count_reg != CNT_MAX)
      curr_count_next = curr_count_reg + 1'b1;
    if (bus.clr_mem)
      mem_count_next = (ADDR_W + 1)'(bus.store_valid_mem && !bus.stall);
    else if (bus.store_valid_mem && !bus.stall && mem_wr_new && mem_count_reg != CNT_MAX)
      mem_count_next = mem_count_reg + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_sel_reg       <= 1'b0;
      rd_bank_reg      <= 1'b0;
      rd_valid_reg     <= 1'b0;
      mem_rd_valid_reg <= 1'b0;
      curr_count_reg   <= '0;
      mem_count_reg    <= '0;
    end else begin
      wr_sel_reg     <= wr_sel_next;
      curr_count_reg <= curr_count_next;
      mem_count_reg  <= mem_count_next;
      if (!bus.stall) begin
        rd_valid_reg     <= bus.rd_en;
        mem_rd_valid_reg <= bus.mem_rd_en;
        if (bus.rd_en) rd_bank_reg <= ~wr_sel_reg;
      end
    end
  end

  // Invalid entries (and the reset state) present as all-zero data.
  assign p_data = curr_rd_hit[rd_bank_reg] ? curr_rd_data[rd_bank_reg] : '0;
  assign m_data = mem_rd_hit ? mem_rd_data : '0;

  assign bus.p_x0         = p_data[4*DATA_W-1 -: DATA_W];
  assign bus.p_x1         = p_data[3*DATA_W-1 -: DATA_W];
  assign bus.p_x2         = p_data[2*DATA_W-1 -: DATA_W];
  assign bus.p_info       = p_data[DATA_W-1:0];
  assign bus.rd_valid     = rd_valid_reg;
  assign bus.rd_hit       = curr_rd_hit[rd_bank_reg];
  assign bus.mem_rd_x0    = m_data[4*DATA_W-1 -: DATA_W];
  assign bus.mem_rd_x1    = m_data[3*DATA_W-1 -: DATA_W];
  assign bus.mem_rd_x2    = m_data[2*DATA_W-1 -: DATA_W];
  assign bus.mem_rd_info  = m_data[DATA_W-1:0];
  assign bus.mem_rd_valid = mem_rd_valid_reg;
  assign bus.curr_count   = curr_count_reg;
  assign bus.mem_count    = mem_count_reg;

endmodule

// File: tb/tb_smem_interval_store.sv
// Scoreboard bench for smem_interval_store; mem-port expectations follow SMEM_STORE_BYPASS_EN.
module tb_smem_interval_store;
  import smem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  smem_interval_store_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  smem_interval_store #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    interval_t data;
    logic      hit;
  } exp_t;

  exp_t      curr_q[$];
  exp_t      mem_q[$];
  int        n_checks = 0;
  int        n_errors = 0;
  logic      curr_issued = 1'b0;
  logic      mem_issued  = 1'b0;
  logic      mon_ci, mon_mi;
  exp_t      mon_e;
  interval_t zero_iv = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic interval_t mk(input logic [63:0] a, b, c, d);
    interval_t r;
    r.x0 = a; r.x1 = b; r.x2 = c; r.info = d;
    return r;
  endfunction

  function automatic interval_t pat(input int a);
    return mk(64'h1000 + 64'(a), 64'h2000 + 64'(a), ~64'(a), 64'(a) << 8);
  endfunction

  task automatic tick();
    @(negedge clk);
    bus.store_valid_curr = 1'b0;
    bus.store_valid_mem  = 1'b0;
    bus.swap             = 1'b0;
    bus.clr_mem          = 1'b0;
    bus.rd_en            = 1'b0;
    bus.mem_rd_en        = 1'b0;
    curr_issued          = 1'b0;
    mem_issued           = 1'b0;
  endtask

  task automatic wr_curr(input int a, input interval_t d);
    bus.store_valid_curr = 1'b1;
    bus.curr_x_addr = ADDR_W'(a);
    bus.curr_x_0 = d.x0; bus.curr_x_1 = d.x1; bus.curr_x_2 = d.x2; bus.curr_x_info = d.info;
  endtask

  task automatic wr_mem(input int a, input interval_t d);
    bus.store_valid_mem = 1'b1;
    bus.mem_x_addr = ADDR_W'(a);
    bus.mem_x_0 = d.x0; bus.mem_x_1 = d.x1; bus.mem_x_2 = d.x2; bus.mem_x_info = d.info;
  endtask

  task automatic rd_curr(input int a, input interval_t d, input logic hit);
    exp_t e;
    e.data = d; e.hit = hit;
    bus.rd_en = 1'b1;
    bus.current_rd_addr = ADDR_W'(a);
    curr_q.push_back(e);
    curr_issued = 1'b1;
  endtask

  task automatic rd_mem(input int a, input interval_t d);
    exp_t e;
    e.data = d; e.hit = 1'b1;
    bus.mem_rd_en = 1'b1;
    bus.mem_rd_addr = ADDR_W'(a);
    mem_q.push_back(e);
    mem_issued = 1'b1;
  endtask

  // Pop one expectation per accepted read, one cycle after the request edge.
  always @(posedge clk) begin
    mon_ci = curr_issued;
    mon_mi = mem_issued;
    #1;
    if (mon_ci) begin
      check("curr_sb_depth", 64'(curr_q.size()), 64'd1);
      if (curr_q.size() != 0) begin
        mon_e = curr_q.pop_front();
        $display("curr read: hit=%0b x0=0x%0h x2=0x%0h", bus.rd_hit, bus.p_x0, bus.p_x2);
        check("rd_valid", 64'(bus.rd_valid), 64'd1);
        check("rd_hit", 64'(bus.rd_hit), 64'(mon_e.hit));
        check("p_x0", bus.p_x0, mon_e.data.x0);
        check("p_x1", bus.p_x1, mon_e.data.x1);
        check("p_x2", bus.p_x2, mon_e.data.x2);
        check("p_info", bus.p_info, mon_e.data.info);
      end
    end
    if (mon_mi) begin
      check("mem_sb_depth", 64'(mem_q.size()), 64'd1);
      if (mem_q.size() != 0) begin
        mon_e = mem_q.pop_front();
        $display("mem read: x0=0x%0h info=0x%0h", bus.mem_rd_x0, bus.mem_rd_info);
        check("mem_rd_valid", 64'(bus.mem_rd_valid), 64'd1);
        check("mem_rd_x0", bus.mem_rd_x0, mon_e.data.x0);
        check("mem_rd_x1", bus.mem_rd_x1, mon_e.data.x1);
        check("mem_rd_x2", bus.mem_rd_x2, mon_e.data.x2);
        check("mem_rd_info", bus.mem_rd_info, mon_e.data.info);
      end
    end
  end

  initial begin
    interval_t d5, d3, d9, m11, maa, m77, old_exp;
    d5  = mk(64'h1, 64'h2, 64'h30, 64'h4);
    d3  = mk(64'h33, 64'h34, 64'h35, 64'h36);
    d9  = mk(64'h91, 64'h92, 64'h93, 64'h94);
    m11 = mk(64'h11, 64'h11, 64'h11, 64'h11);
    maa = mk(64'hAA, 64'hAB, 64'hAC, 64'hAD);
    m77 = mk(64'h77, 64'h78, 64'h79, 64'h7A);
`ifdef SMEM_STORE_BYPASS_EN
    old_exp = maa;
`else
    old_exp = m11;
`endif
    bus.stall = 1'b0; bus.swap = 1'b0; bus.clr_mem = 1'b0;
    bus.store_valid_curr = 1'b0; bus.store_valid_mem = 1'b0;
    bus.curr_x_addr = '0; bus.mem_x_addr = '0;
    bus.curr_x_0 = '0; bus.curr_x_1 = '0; bus.curr_x_2 = '0; bus.curr_x_info = '0;
    bus.mem_x_0 = '0; bus.mem_x_1 = '0; bus.mem_x_2 = '0; bus.mem_x_info = '0;
    bus.rd_en = 1'b0; bus.current_rd_addr = '0; bus.mem_rd_en = 1'b0; bus.mem_rd_addr = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("rst_curr_count", 64'(bus.curr_count), 64'd0);
    check("rst_mem_count", 64'(bus.mem_count), 64'd0);
    check("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    check("rst_rd_hit", 64'(bus.rd_hit), 64'd0);
    check("rst_p_x2", bus.p_x2, 64'd0);
    check("rst_mem_rd_valid", 64'(bus.mem_rd_valid), 64'd0);
    check("rst_mem_rd_x0", bus.mem_rd_x0, 64'd0);

    wr_curr(5, d5); tick();
    check("curr_count_w5", 64'(bus.curr_count), 64'd1);
    bus.swap = 1'b1; tick();
    check("curr_count_swap1", 64'(bus.curr_count), 64'd0);
    rd_curr(5, d5, 1'b1); tick();
    rd_curr(6, zero_iv, 1'b0); tick();

    bus.stall = 1'b1;
    repeat (3) begin wr_curr(3, d3); tick(); end
    check("curr_count_stalled", 64'(bus.curr_count), 64'd0);
    bus.stall = 1'b0;
    wr_curr(3, d3); tick();
    check("curr_count_restall", 64'(bus.curr_count), 64'd1);

    wr_curr(9, d9); bus.swap = 1'b1; tick();
    check("curr_count_swap_wr", 64'(bus.curr_count), 64'd0);
    rd_curr(9, d9, 1'b1); tick();
    rd_curr(3, d3, 1'b1); tick();
    bus.swap = 1'b1; tick();
    rd_curr(9, zero_iv, 1'b0); tick();

    wr_mem(2, m11); tick();
    check("mem_count_w2", 64'(bus.mem_count), 64'd1);
    wr_mem(2, maa); rd_mem(2, old_exp); tick();
    check("mem_count_rewrite", 64'(bus.mem_count), 64'd1);
    rd_mem(2, maa); tick();
    bus.clr_mem = 1'b1; wr_mem(7, m77); tick();
    check("mem_count_clr_wr", 64'(bus.mem_count), 64'd1);
    rd_mem(2, zero_iv); tick();
    rd_mem(7, m77); tick();

    // Stalled requests are dropped; outputs hold the last mem read.
    bus.stall = 1'b1;
    bus.mem_rd_en = 1'b1; bus.mem_rd_addr = ADDR_W'(2);
    @(negedge clk); @(negedge clk);
    check("stall_hold_mem_x0", bus.mem_rd_x0, m77.x0);
    check("stall_hold_mem_valid", 64'(bus.mem_rd_valid), 64'd1);
    bus.stall = 1'b0; bus.mem_rd_en = 1'b0;
    tick();

    for (int i = 0; i < DEPTH; i++) begin wr_curr(i, pat(i)); tick(); end
    wr_curr(0, pat(0)); tick();
    wr_curr(1, pat(1)); tick();
    check("curr_count_sat", 64'(bus.curr_count), 64'(DEPTH));
    bus.swap = 1'b1; tick();
    wr_curr(1, pat(1)); rd_curr(4, pat(4), 1'b1); tick();
    check("curr_count_prerst", 64'(bus.curr_count), 64'd1);

    #2 rst = 1'b1;
    #1;
    check("arst_curr_count", 64'(bus.curr_count), 64'd0);
    check("arst_mem_count", 64'(bus.mem_count), 64'd0);
    check("arst_rd_valid", 64'(bus.rd_valid), 64'd0);
    check("arst_rd_hit", 64'(bus.rd_hit), 64'd0);
    check("arst_p_x0", bus.p_x0, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    rd_curr(4, zero_iv, 1'b0); tick();
    tick();
    check("curr_sb_left", 64'(curr_q.size()), 64'd0);
    check("mem_sb_left", 64'(mem_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
